// File: rtl/com_bus_mem_responder_pkg.sv
// rtl/com_bus_mem_responder_pkg.sv - shared widths, defaults and bus FSM state encodings
package com_bus_mem_responder_pkg;

  localparam int ADDRESSSIZE   = 32;
  localparam int DEF_N_CORES   = 4;
  localparam int DEF_MEM_DEPTH = 1024;
  localparam int DEF_MEM_LAT   = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_DATA  = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_INV_WAIT = 3'd5,
    ST_RELEASE  = 3'd6
  } bus_state_e;

endpackage

// File: rtl/com_bus_arbiter.sv
// rtl/com_bus_arbiter.sv - snoop-priority plus round-robin proc grant logic
module com_bus_arbiter
  import com_bus_mem_responder_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CORES-1:0] req_proc,
  input  logic [N_CORES-1:0] req_snoop,
  input  logic               eval,
  input  logic               clr,
  output logic [N_CORES-1:0] gnt_proc,
  output logic [N_CORES-1:0] gnt_snoop,
  output logic               any_req
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      proc_idx;
  logic [N_CORES-1:0] snoop_win;
  logic [N_CORES-1:0] proc_win;
  logic               snoop_found;
  logic               proc_found;
  int                 idx;

  assign any_req = (|req_proc) | (|req_snoop);

  // Pick the lowest-index snoop requester and the first proc requester at or after ptr.
  always_comb begin
    snoop_win   = '0;
    proc_win    = '0;
    proc_idx    = ptr;
    snoop_found = 1'b0;
    proc_found  = 1'b0;
    idx         = 0;
    for (int i = 0; i < N_CORES; i++) begin
      if (req_snoop[i] && !snoop_found) begin
        snoop_win[i] = 1'b1;
        snoop_found  = 1'b1;
      end
    end
    for (int i = 0; i < N_CORES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (req_proc[idx] && !proc_found) begin
        proc_win[idx] = 1'b1;
        proc_idx      = PW'(idx);
        proc_found    = 1'b1;
      end
    end
  end

  // Registered grants; only snoop-free proc grants advance the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_proc  <= '0;
      gnt_snoop <= '0;
      ptr       <= '0;
    end else if (clr) begin
      gnt_proc  <= '0;
      gnt_snoop <= '0;
    end else if (eval && any_req) begin
      if (snoop_found) begin
        gnt_snoop <= snoop_win;
      end else begin
        gnt_proc <= proc_win;
        ptr      <= (proc_idx == PW'(N_CORES - 1)) ? '0 : proc_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_bus_mem_responder.sv
// rtl/com_bus_mem_responder.sv - bus arbiter, main memory and coherence flag combiner
module com_bus_mem_responder
  import com_bus_mem_responder_pkg::*;
#(
  parameter int N_CORES   = DEF_N_CORES,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int MEM_LAT   = DEF_MEM_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CORES-1:0]     Com_Bus_Req_proc,
  output logic [N_CORES-1:0]     Com_Bus_Gnt_proc,
  input  logic [N_CORES-1:0]     Com_Bus_Req_snoop,
  output logic [N_CORES-1:0]     Com_Bus_Gnt_snoop,
  input  logic [ADDRESSSIZE-1:0] Address_Com,
  inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
  input  logic                   BusRd,
  input  logic                   BusRdX,
  input  logic                   Invalidate,
  inout  wire                    Data_in_Bus,
  input  logic                   Mem_wr,
  input  logic                   Mem_oprn_abort,
  output logic                   Mem_write_done,
  input  logic [N_CORES-1:0]     Invalidation_done,
  output logic                   All_Invalidation_done,
  input  logic [N_CORES-1:0]     Shared_local,
  output logic                   Shared
);

  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  bus_state_e state, next_state;

  logic [ADDRESSSIZE-1:0] mem [MEM_DEPTH];
  logic [AW-1:0]          addr_q;
  logic [ADDRESSSIZE-1:0] wdata_q;
  logic [ADDRESSSIZE-1:0] rd_data_q;
  logic [CNT_W-1:0]       cnt;
  logic [N_CORES-1:0]     gnt_any;
  logic                   req_held;
  logic                   any_req;
  logic                   arb_eval, clr_gnt, ld_rd, ld_wr, wr_commit, rd_fetch;
  logic                   addr_hi_unused;

  assign addr_hi_unused = ^Address_Com[ADDRESSSIZE-1:AW];

  assign Shared   = |Shared_local;
  assign gnt_any  = Com_Bus_Gnt_proc | Com_Bus_Gnt_snoop;
  assign req_held = |((Com_Bus_Gnt_proc & Com_Bus_Req_proc) |
                      (Com_Bus_Gnt_snoop & Com_Bus_Req_snoop));

  assign Data_Bus_Com = (state == ST_RD_DATA) ? rd_data_q : 'z;
  assign Data_in_Bus  = (state == ST_RD_DATA) ? 1'b1 : 1'bz;

  com_bus_arbiter #(.N_CORES(N_CORES)) u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req_proc  (Com_Bus_Req_proc),
    .req_snoop (Com_Bus_Req_snoop),
    .eval      (arb_eval),
    .clr       (clr_gnt),
    .gnt_proc  (Com_Bus_Gnt_proc),
    .gnt_snoop (Com_Bus_Gnt_snoop),
    .any_req   (any_req)
  );

  // Bus tenure state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state and per-state control strobes; the grant is cleared on the way back to IDLE.
  always_comb begin
    next_state = state;
    arb_eval   = 1'b0;
    clr_gnt    = 1'b0;
    ld_rd      = 1'b0;
    ld_wr      = 1'b0;
    wr_commit  = 1'b0;
    rd_fetch   = 1'b0;
    case (state)
      ST_IDLE: begin
        arb_eval = 1'b1;
        if (any_req) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        if (Mem_wr) begin
          ld_wr      = 1'b1;
          next_state = ST_WR_WAIT;
        end else if (BusRdX || BusRd) begin
          ld_rd      = 1'b1;
          next_state = ST_RD_WAIT;
        end else if (Invalidate) begin
          next_state = ST_INV_WAIT;
        end else begin
          next_state = ST_RELEASE;
        end
      end
      ST_RD_WAIT: begin
        if (!req_held) begin
          clr_gnt    = 1'b1;
          next_state = ST_IDLE;
        end else if (Mem_oprn_abort) begin
          next_state = ST_RELEASE;
        end else if (cnt == CNT_W'(1)) begin
          rd_fetch   = 1'b1;
          next_state = ST_RD_DATA;
        end
      end
      ST_WR_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          wr_commit  = 1'b1;
          next_state = ST_RELEASE;
        end
      end
      ST_RD_DATA, ST_INV_WAIT, ST_RELEASE: begin
        if (!req_held) begin
          clr_gnt    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Address/data capture, latency counter, write-done pulse and invalidation summary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q                <= '0;
      wdata_q               <= '0;
      cnt                   <= '0;
      Mem_write_done        <= 1'b0;
      All_Invalidation_done <= 1'b0;
    end else begin
      Mem_write_done        <= wr_commit;
      All_Invalidation_done <= (Invalidate | BusRdX) & (|gnt_any) &
                               (&(Invalidation_done | gnt_any));
      if (ld_rd || ld_wr) begin
        addr_q <= Address_Com[AW-1:0];
        cnt    <= CNT_W'(MEM_LAT);
      end else if ((state == ST_RD_WAIT || state == ST_WR_WAIT) && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (ld_wr) wdata_q <= Data_Bus_Com;
    end
  end

  // Memory array: contents survive reset; read data is captured as RD_DATA is entered.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[addr_q] <= wdata_q;
    if (rd_fetch)  rd_data_q   <= mem[addr_q];
  end

endmodule

// File: tb/tb_com_bus_mem_responder.sv
// tb/tb_com_bus_mem_responder.sv - directed self-checking bench for com_bus_mem_responder
module tb_com_bus_mem_responder;

  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int DW  = 32;

  typedef struct {
    logic [N-1:0] pattern;
    logic         expect_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_proc, req_snoop, gnt_proc, gnt_snoop, inv_done, shared_local;
  logic [DW-1:0] address, tb_data;
  logic tb_drive;
  wire  [DW-1:0] data_bus;
  wire  data_in_bus;
  logic bus_rd, bus_rdx, invalidate, mem_wr, abort, write_done, all_inv_done, shared;
  int   n_checks = 0;
  int   n_fail   = 0;

  vec_t shared_vecs[4];
  vec_t inv_vecs[5];

  assign data_bus = tb_drive ? tb_data : 'z;

  always #5 clk = ~clk;

  com_bus_mem_responder dut (
    .clk                   (clk),
    .rst                   (rst),
    .Com_Bus_Req_proc      (req_proc),
    .Com_Bus_Gnt_proc      (gnt_proc),
    .Com_Bus_Req_snoop     (req_snoop),
    .Com_Bus_Gnt_snoop     (gnt_snoop),
    .Address_Com           (address),
    .Data_Bus_Com          (data_bus),
    .BusRd                 (bus_rd),
    .BusRdX                (bus_rdx),
    .Invalidate            (invalidate),
    .Data_in_Bus           (data_in_bus),
    .Mem_wr                (mem_wr),
    .Mem_oprn_abort        (abort),
    .Mem_write_done        (write_done),
    .Invalidation_done     (inv_done),
    .All_Invalidation_done (all_inv_done),
    .Shared_local          (shared_local),
    .Shared                (shared)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] driving();
    return {31'b0, (data_in_bus === 1'b1)};
  endfunction

  task automatic clear_inputs();
    req_proc = '0; req_snoop = '0; address = '0; tb_data = '0; tb_drive = 1'b0;
    bus_rd = 1'b0; bus_rdx = 1'b0; invalidate = 1'b0; mem_wr = 1'b0; abort = 1'b0;
    inv_done = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_write(input int core, input logic [DW-1:0] addr, input logic [DW-1:0] data);
    int pulses = 0;
    int first = -1;
    req_proc[core] = 1'b1; mem_wr = 1'b1; address = addr; tb_data = data; tb_drive = 1'b1;
    for (int c = 1; c <= LAT + 4; c++) begin
      tick();
      if (c == 1) check("wr_grant", gnt_proc, 32'(1) << core);
      if (write_done) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    check("wr_pulse_count", pulses, 1);
    check("wr_pulse_cycle", first, LAT + 2);
    req_proc[core] = 1'b0; mem_wr = 1'b0; tb_drive = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_read(input int core, input logic [DW-1:0] addr, input logic [DW-1:0] exp);
    req_proc[core] = 1'b1; bus_rd = 1'b1; address = addr;
    tick();
    check("rd_grant", gnt_proc, 32'(1) << core);
    repeat (LAT) tick();
    check("rd_no_early_drive", driving(), 0);
    tick();
    check("rd_data_in_bus", driving(), 1);
    check("rd_data", data_bus, exp);
    req_proc[core] = 1'b0; bus_rd = 1'b0;
    tick();
    check("rd_release_gnt", gnt_proc, 0);
    check("rd_release_drive", driving(), 0);
    tick();
  endtask

  task automatic rd_abort(input int abort_after);
    logic drove = 1'b0;
    req_proc[0] = 1'b1; bus_rd = 1'b1; address = 32'h10;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (data_in_bus === 1'b1) drove = 1'b1;
      abort = (t == abort_after);
    end
    check("abort_no_drive", drove, 0);
    check("abort_gnt_held", gnt_proc, 4'b0001);
    req_proc = '0; bus_rd = 1'b0; abort = 1'b0;
    tick();
    check("abort_release_gnt", gnt_proc, 0);
    tick();
  endtask

  task automatic wait_grant(output int got);
    got = -1;
    for (int w = 0; w < 10 && got < 0; w++) begin
      tick();
      for (int j = 0; j < N; j++) if (gnt_proc == (4'b0001 << j)) got = j;
    end
  endtask

  initial begin
    int got;
    shared_vecs[0] = '{4'b0000, 1'b0};
    shared_vecs[1] = '{4'b0010, 1'b1};
    shared_vecs[2] = '{4'b1000, 1'b1};
    shared_vecs[3] = '{4'b1111, 1'b1};
    inv_vecs[0] = '{4'b0110, 1'b0};
    inv_vecs[1] = '{4'b1110, 1'b1};
    inv_vecs[2] = '{4'b0111, 1'b0};
    inv_vecs[3] = '{4'b1111, 1'b1};
    inv_vecs[4] = '{4'b1100, 1'b0};

    shared_local = '0;
    do_reset();
    check("reset_gnt_proc", gnt_proc, 0);
    check("reset_gnt_snoop", gnt_snoop, 0);
    check("reset_write_done", write_done, 0);
    check("reset_all_inv", all_inv_done, 0);
    check("reset_drive", driving(), 0);

    for (int i = 0; i < 4; i++) begin
      shared_local = shared_vecs[i].pattern;
      #1;
      check("shared_or", shared, shared_vecs[i].expect_out);
    end
    shared_local = '0;

    do_write(1, 32'h10, 32'hA5A5);
    do_read(2, 32'h10, 32'hA5A5);
    do_write(1, 32'h20, 32'h1234);
    do_read(3, 32'h20, 32'h1234);

    rd_abort(3);
    rd_abort(5);

    do_reset();
    req_proc = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_grant(got);
      check("rr_order", got, k);
      if (got >= 0) begin
        tick();
        tick();
        req_proc[got] = 1'b0;
      end else begin
        req_proc = '0;
      end
      tick();
    end
    req_proc = 4'b1111;
    wait_grant(got);
    check("rr_wrap", got, 0);
    req_proc = '0;
    tick();
    tick();

    req_proc = 4'b0001; req_snoop = 4'b1000;
    tick();
    check("snoop_first_snoop", gnt_snoop, 4'b1000);
    check("snoop_first_proc", gnt_proc, 0);
    tick();
    req_snoop = '0;
    tick();
    tick();
    check("proc_after_snoop", gnt_proc, 4'b0001);
    check("proc_after_snoop_sn", gnt_snoop, 0);
    req_snoop = 4'b0100;
    tick();
    tick();
    check("no_nested_snoop", gnt_snoop, 0);
    req_proc = '0;
    tick();
    tick();
    check("snoop_after_idle", gnt_snoop, 4'b0100);
    req_snoop = '0;
    tick();
    tick();

    req_proc[0] = 1'b1; invalidate = 1'b1; inv_done = '0;
    tick();
    tick();
    check("inv_start", all_inv_done, 0);
    for (int i = 0; i < 5; i++) begin
      inv_done = inv_vecs[i].pattern;
      tick();
      check("all_inv_done", all_inv_done, inv_vecs[i].expect_out);
    end
    inv_done = 4'b1111;
    invalidate = 1'b0;
    tick();
    check("all_inv_gated", all_inv_done, 0);
    req_proc = '0; inv_done = '0;
    tick();
    tick();

    do_write(0, 32'h30, 32'h1111);
    req_proc[1] = 1'b1; mem_wr = 1'b1; address = 32'h30; tb_data = 32'h2222; tb_drive = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_gnt", gnt_proc, 0);
    check("midrst_done", write_done, 0);
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    do_read(2, 32'h30, 32'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/com_bus_mem_responder.md
Name: com_bus_mem_responder

Overview:
- Responder end of the common snooping bus used by the four cache_wrapper instances.
- Arbitrates Com_Bus_Req_proc / Com_Bus_Req_snoop from all cores and issues one-hot grants.
- Acts as main memory for BusRd, BusRdX and Mem_wr transactions, and honours Mem_oprn_abort when a snooping cache supplies the data.
- Combines per-core Shared_local and Invalidation_done into the global Shared and All_Invalidation_done.

Parameters:
- N_CORES, 4, number of cache_wrapper instances on the bus.
- MEM_DEPTH, 1024, memory words; index = Address_Com[clog2(MEM_DEPTH)-1:0].
- MEM_LAT, 4, cycles from read/write acceptance to data valid / write done (>=1).

Ports:
- clk  in  1  bus clock
- rst  in  1  asynchronous active-high reset
- Com_Bus_Req_proc  in  N_CORES  per-core processor-side bus request
- Com_Bus_Gnt_proc  out  N_CORES  one-hot processor-side grant
- Com_Bus_Req_snoop  in  N_CORES  per-core snoop write-back request
- Com_Bus_Gnt_snoop  out  N_CORES  one-hot snoop grant
- Address_Com  in  `ADDRESSSIZE  bus address, driven by the granted cache
- Data_Bus_Com  inout  `ADDRESSSIZE  bus data; driven here only in RD_DATA, else Z
- BusRd  in  1  read transaction
- BusRdX  in  1  read-exclusive transaction
- Invalidate  in  1  invalidate-only transaction
- Data_in_Bus  inout  1  driven 1 here in RD_DATA, else Z
- Mem_wr  in  1  write-back request, data on Data_Bus_Com
- Mem_oprn_abort  in  1  snooper owns the line; abort the pending read
- Mem_write_done  out  1  one-cycle pulse on write completion
- Invalidation_done  in  N_CORES  per-core invalidation acknowledge
- All_Invalidation_done  out  1  all non-requesting cores acknowledged
- Shared_local  in  N_CORES  per-core "line present" flag
- Shared  out  1  OR of Shared_local

Behaviour:
- Reset values (asynchronous): all grants 0, Mem_write_done 0, All_Invalidation_done 0, state IDLE, round-robin pointer 0, latency counter 0, Data_Bus_Com and Data_in_Bus Z. Memory contents are not reset.
- Shared: purely combinational OR of Shared_local.

Arbitration:
- Evaluated in IDLE only.
- Any snoop request wins over proc requests; lowest index wins among snoop requests.
- Proc requests are served round-robin starting at pointer; pointer = winner+1 mod N_CORES after each proc grant.
- Grant registered: asserted the cycle after IDLE sees a request, held until that core drops its request.

State machine (IDLE, DECODE, RD_WAIT, RD_DATA, WR_WAIT, INV_WAIT, RELEASE):
- DECODE, first cycle with a grant; priority Mem_wr > BusRdX > BusRd > Invalidate; none asserted -> RELEASE.
- BusRd / BusRdX: latch the address and load the counter with MEM_LAT -> RD_WAIT.
- RD_WAIT: counter decrements each cycle.
  - Counter reaches 0 -> RD_DATA.
  - Mem_oprn_abort seen -> RELEASE; memory never drives the bus.
  - Abort in the same cycle the counter reaches 0: abort wins.
- RD_DATA: drive mem[addr] on Data_Bus_Com and Data_in_Bus=1; hold until the requester drops its request -> IDLE.
- Mem_wr: latch address and data -> WR_WAIT.
  - After MEM_LAT cycles, write mem and pulse Mem_write_done for one cycle -> RELEASE.
  - Mem_oprn_abort is ignored during writes.
- Invalidate (and BusRdX concurrently): All_Invalidation_done = AND of Invalidation_done over all cores except the granted one. It is registered, with 1-cycle latency, and is only nonzero while Invalidate or BusRdX is high.
- RELEASE: wait until the granted request drops; clear grant -> IDLE. The grant drops the cycle after the request drops.
- Request withdrawn during RD_WAIT / WR_WAIT: finish the write anyway; a read is discarded -> IDLE.
- A snoop request during a proc tenure is not granted until IDLE (no nesting).
- rst mid-transaction: immediate return to the reset values; an in-flight write is lost.

Decomposition:
- Extend the shared cache_def include with `N_CORES, `MEM_LAT and the state encodings; reuse `ADDRESSSIZE.
- Sub-module com_bus_arbiter: priority-snoop plus round-robin-proc grant logic with pointer register.

Test Plan:
- Reset, then core2 asserts Com_Bus_Req_proc with BusRd at addr 0x10 (mem=0xA5A5) -> Com_Bus_Gnt_proc=4'b0100 one cycle later; Data_Bus_Com=0xA5A5 and Data_in_Bus=1 exactly MEM_LAT+2 cycles after the request.
- Core1 Mem_wr addr 0x20 data 0x1234 -> Mem_write_done pulses once after MEM_LAT cycles; a subsequent BusRd of 0x20 returns 0x1234.
- All four cores request proc simultaneously, each holds for 3 cycles -> grant order 0,1,2,3, then 0 again on re-request.
- Core0 proc and core3 snoop requests in the same cycle -> Com_Bus_Gnt_snoop=4'b1000 first, then Com_Bus_Gnt_proc=4'b0001.
- BusRd, then Mem_oprn_abort in RD_WAIT cycle 2 -> Data_Bus_Com stays Z, FSM goes to RELEASE; the same test with abort on the final count cycle also yields no drive.
- Core0 Invalidate with Invalidation_done=4'b0110, then 4'b1110 -> All_Invalidation_done stays 0, then 1 one cycle later. Shared_local=4'b0010 -> Shared=1 combinationally.
